// File: rtl/queue_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : queue_drain_if
// Brief    : Byte-queue read port plus downstream valid/ready byte stream.
// Revision : 1.0 - initial release
// ============================================================================
interface queue_drain_if #(
    parameter int SIZE_W = 10
) ();
    logic [SIZE_W-1:0] q_size;
    logic              q_insert;
    logic [7:0]        q_data;
    logic              q_read;
    logic              m_valid;
    logic [7:0]        m_data;
    logic              m_ready;

    // master: the drain controller; slave: queue plus downstream consumer
    modport master (
        input  q_size, q_insert, q_data, m_ready,
        output q_read, m_valid, m_data
    );
    modport slave (
        output q_size, q_insert, q_data, m_ready,
        input  q_read, m_valid, m_data
    );
endinterface
`default_nettype wire

// File: rtl/queue_drain.sv
`default_nettype none
// ============================================================================
// Module   : queue_drain
// Brief    : Credit-based reader for the SRAM byte queue feeding a skid FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module queue_drain #(
    parameter int SIZE_W       = 10,
    parameter int READ_LATENCY = 1,
    parameter int BUF_DEPTH    = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    queue_drain_if.master     bus,
    output logic              busy,
    output logic [15:0]       drained_cnt
);
    localparam int c_PTR_W = $clog2(BUF_DEPTH);
    localparam int c_SUM_W = c_PTR_W + 2;

    logic [READ_LATENCY-1:0] r_tag;
    logic [7:0]              r_mem [BUF_DEPTH];
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_PTR_W:0]        r_count;
    logic [15:0]             r_drained;

    logic [c_SUM_W-1:0]      w_inflight;
    logic [c_SUM_W-1:0]      w_credit_used;
    logic                    w_read;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_valid;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_inflight = w_inflight + c_SUM_W'(r_tag[i]);
        end
    end

    // Every outstanding read owns a FIFO slot, so the FIFO can never overflow
    assign w_credit_used = w_inflight + c_SUM_W'(r_count);
    assign w_read  = !rst && !bus.q_insert && (bus.q_size != SIZE_W'(0))
                     && (w_credit_used < c_SUM_W'(BUF_DEPTH));
    assign w_push  = r_tag[READ_LATENCY-1];
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && bus.m_ready;

    generate
        if (READ_LATENCY == 1) begin : g_tag_single
            always_ff @(posedge clk) begin
                if (rst) r_tag <= '0;
                else     r_tag <= w_read;
            end
        end else begin : g_tag_shift
            always_ff @(posedge clk) begin
                if (rst) r_tag <= '0;
                else     r_tag <= {r_tag[READ_LATENCY-2:0], w_read};
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.q_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_drained <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_drained <= r_drained + 16'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && w_push && !w_pop) begin
            assert (r_count != (c_PTR_W + 1)'(BUF_DEPTH))
                else $error("queue_drain: skid FIFO overflow");
        end
    end
`endif

    // Gate the head entry so the stream reads zero while the FIFO is empty
    assign bus.m_data  = w_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign bus.m_valid = w_valid;
    assign bus.q_read  = w_read;
    assign busy        = (w_inflight != '0) || w_valid;
    assign drained_cnt = r_drained;
endmodule
`default_nettype wire

// File: tb/tb_queue_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_queue_drain
// Brief    : Directed bench with a queue model and byte-order scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_queue_drain;
    localparam int SIZE_W       = 10;
    localparam int READ_LATENCY = 1;
    localparam int BUF_DEPTH    = 4;
    localparam int N_STREAM     = 65537;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [15:0] drained_cnt;

    always #5 clk = ~clk;

    queue_drain_if #(.SIZE_W(SIZE_W)) bus ();

    queue_drain #(
        .SIZE_W       (SIZE_W),
        .READ_LATENCY (READ_LATENCY),
        .BUF_DEPTH    (BUF_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .drained_cnt (drained_cnt)
    );

    // Queue model: registered pointers, one-cycle read data, filler otherwise
    logic [7:0] mem [0:131071];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       ld_en   = 1'b0;
    int         ld_cnt  = 0;
    logic       q_clear = 1'b0;

    assign bus.q_size = SIZE_W'(wr_ptr - rd_ptr);

    always @(posedge clk) begin
        if (q_clear)          rd_ptr <= wr_ptr;
        else if (bus.q_read)  rd_ptr <= rd_ptr + 1;
        wr_ptr     <= wr_ptr + (ld_en ? ld_cnt : 0) + (bus.q_insert ? 1 : 0);
        bus.q_data <= bus.q_read ? mem[rd_ptr] : 8'hEE;
    end

    int         checks = 0;
    int         errors = 0;
    int         exp_drained = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr + i] = base + 8'(i);
            exp_q.push_back(base + 8'(i));
        end
        ld_cnt = n;
        ld_en  = 1'b1;
        tick();
        ld_en  = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int limit);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < limit) begin
            tick();
            guard++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    // Scoreboard: every accepted byte must match the oldest expected byte
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_drained = 0;
            end else if (bus.m_valid && bus.m_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_underflow: observed byte 0x%0h expected none", bus.m_data);
                end
                if (exp_q.size() != 0) begin
                    b = exp_q.pop_front();
                    check("m_data_order", bus.m_data, b);
                end
                exp_drained++;
            end
        end
    end

    initial begin
        int nreads;
        int sent;
        int guard;
        int n;

        bus.q_insert = 1'b0;
        bus.m_ready  = 1'b1;

        // Reset with an empty queue
        repeat (3) tick();
        check("rst_q_read",   bus.q_read,  0);
        check("rst_m_valid",  bus.m_valid, 0);
        check("rst_m_data",   bus.m_data,  0);
        check("rst_busy",     busy,        0);
        check("rst_drained",  drained_cnt, 0);
        rst = 1'b0;
        #1;
        for (int c = 0; c < 10; c++) begin
            check("idle_q_read",  bus.q_read,  0);
            check("idle_m_valid", bus.m_valid, 0);
            check("idle_busy",    busy,        0);
            tick();
        end

        // Preloaded queue, full-rate drain
        rst = 1'b1;
        tick();
        preload(8, 8'h10);
        rst = 1'b0;
        #1;
        for (int c = 0; c < 12; c++) begin
            check("stream_q_read",  bus.q_read,  (c < 8) ? 1 : 0);
            check("stream_m_valid", bus.m_valid, (c >= 2 && c < 10) ? 1 : 0);
            @(posedge clk);
            #2;
        end
        check("stream_drained", drained_cnt, 8);
        check("stream_sb_cnt",  drained_cnt, exp_drained);

        // Backpressure: only BUF_DEPTH reads may be outstanding
        bus.m_ready = 1'b0;
        tick();
        preload(8, 8'h20);
        nreads = 0;
        repeat (10) begin
            if (bus.q_read) nreads++;
            tick();
        end
        check("bp_reads",   nreads,      BUF_DEPTH);
        check("bp_q_read",  bus.q_read,  0);
        check("bp_m_valid", bus.m_valid, 1);
        check("bp_m_data",  bus.m_data,  8'h20);
        check("bp_busy",    busy,        1);
        bus.m_ready = 1'b1;
        wait_drain("bp_drain", 100);
        tick();
        check("bp_drained", drained_cnt, 16);
        check("bp_idle",    busy,        0);

        // Insert cycle blocks the read that would otherwise issue
        preload(1, 8'h30);
        mem[wr_ptr]  = 8'h31;
        exp_q.push_back(8'h31);
        bus.q_insert = 1'b1;
        #1;
        check("ins_q_read_blocked", bus.q_read, 0);
        tick();
        bus.q_insert = 1'b0;
        #1;
        check("ins_q_read_next", bus.q_read, 1);
        wait_drain("ins_drain", 100);
        tick();
        check("ins_drained", drained_cnt, 18);
        check("ins_m_valid", bus.m_valid, 0);

        // Reset with two bytes buffered and one in flight
        bus.m_ready = 1'b0;
        tick();
        preload(3, 8'h40);
        repeat (3) tick();
        check("mid_m_valid", bus.m_valid, 1);
        check("mid_busy",    busy,        1);
        rst     = 1'b1;
        q_clear = 1'b1;
        exp_q.delete();
        tick();
        check("mid_rst_m_valid", bus.m_valid, 0);
        check("mid_rst_busy",    busy,        0);
        check("mid_rst_drained", drained_cnt, 0);
        rst         = 1'b0;
        q_clear     = 1'b0;
        bus.m_ready = 1'b1;
        repeat (3) begin
            tick();
            check("mid_post_m_valid", bus.m_valid, 0);
            check("mid_post_busy",    busy,        0);
        end

        // Long stream across the 16-bit counter wrap
        sent  = 0;
        guard = 0;
        while (sent < N_STREAM && guard < 80000) begin
            if (bus.q_size < 512) begin
                n = ((N_STREAM - sent) < 256) ? (N_STREAM - sent) : 256;
                for (int i = 0; i < n; i++) begin
                    mem[wr_ptr + i] = 8'((sent + i) * 7 + 3);
                    exp_q.push_back(8'((sent + i) * 7 + 3));
                end
                ld_cnt = n;
                ld_en  = 1'b1;
                sent   = sent + n;
            end else begin
                ld_en = 1'b0;
            end
            tick();
            guard++;
        end
        ld_en = 1'b0;
        check("wrap_fed", sent, N_STREAM);
        wait_drain("wrap_drain", 3000);
        tick();
        check("wrap_sb_cnt",  exp_drained, N_STREAM);
        check("wrap_drained", drained_cnt, 16'h0001);
        check("wrap_idle",    busy,        0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
